// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - issue/result bundle between the control path and the ALU sequencer
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rem;
    logic             divz;

    modport master (
        output start, sel, a, b, alu_y,
        input  busy, done, result, rem, divz
    );

    modport slave (
        input  start, sel, a, b, alu_y,
        output busy, done, result, rem, divz
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU issue sequencer: single-cycle pass-through plus iterative MUL/DIV
// Optional macro ALU_SEQ_DIVZERO_EN: divide-by-zero completes in one cycle and raises divz.
module alu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [3:0] SEL_MUL = 4'b0010;
    localparam logic [3:0] SEL_DIV = 4'b0011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic             divz_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] part;

    logic [WIDTH-1:0] mul_next;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] part_next;
    logic             last;
    logic             dz_fast;

    // Restoring step: quo doubles as the dividend shift register, its MSB feeds the partial remainder.
    always_comb begin
        mul_next  = acc + (opb[0] ? opa : '0);
        shifted   = {part, quo[WIDTH-1]};
        fits      = (shifted >= {1'b0, opb});
        diff      = shifted - {1'b0, opb};
        quo_next  = {quo[WIDTH-2:0], fits};
        part_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        last      = (cnt == CW'(WIDTH - 1));
    end

`ifdef ALU_SEQ_DIVZERO_EN
    assign dz_fast = (bus.sel == SEL_DIV) && (bus.b == '0);
`else
    assign dz_fast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            divz_q <= 1'b0;
            res_q  <= '0;
            rem_q  <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            quo    <= '0;
            part   <= '0;
        end else begin
            done_q <= 1'b0;
            divz_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        opa  <= bus.a;
                        opb  <= bus.b;
                        acc  <= '0;
                        quo  <= bus.a;
                        part <= '0;
                        cnt  <= '0;
                        if (dz_fast) begin
                            res_q  <= '1;
                            rem_q  <= bus.a;
                            divz_q <= 1'b1;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else if (bus.sel == SEL_MUL) begin
                            busy_q <= 1'b1;
                            state  <= MUL;
                        end else if (bus.sel == SEL_DIV) begin
                            busy_q <= 1'b1;
                            state  <= DIV;
                        end else begin
                            res_q  <= bus.alu_y;
                            rem_q  <= '0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        res_q  <= mul_next;
                        rem_q  <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DIV: begin
                    quo  <= quo_next;
                    part <= part_next;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        res_q  <= quo_next;
                        rem_q  <= part_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.rem    = rem_q;
    assign bus.divz   = divz_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_ctrl_if #(.WIDTH(W)) bus ();
    alu_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [W-1:0] rm;
        logic         dz;
        int           lat;
        int           stamp;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 64'(bus.done), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_result"}, 64'(bus.result), 64'(e.res));
                    check({e.name, "_rem"}, 64'(bus.rem), 64'(e.rm));
                    check({e.name, "_divz"}, 64'(bus.divz), 64'(e.dz));
                    check({e.name, "_latency"}, 64'(cyc - e.stamp), 64'(e.lat));
                end
            end
        end
    end

    task automatic drive(input logic [3:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] yv);
        bus.start = 1'b1;
        bus.sel   = s;
        bus.a     = av;
        bus.b     = bv;
        bus.alu_y = yv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.alu_y = $urandom;
        bus.sel   = 4'($urandom);
    endtask

    task automatic issue(input string nm, input logic [3:0] s, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] yv,
                         input logic [W-1:0] er, input logic [W-1:0] erm,
                         input logic edz, input int lat);
        exp_t e;
        e.name  = nm;
        e.res   = er;
        e.rm    = erm;
        e.dz    = edz;
        e.lat   = lat;
        e.stamp = cyc;
        sbq.push_back(e);
        drive(s, av, bv, yv);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 120; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check({nm, "_drained"}, 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    initial begin
        int nb;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sel   = 4'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.alu_y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_rem", 64'(bus.rem), 64'd0);
        check("rst_divz", 64'(bus.divz), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("t1_add", 4'b0000, 32'd2, 32'd3, 32'h5, 32'h5, 32'd0, 1'b0, 1);
        check("t1_busy", 64'(bus.busy), 64'd0);
        drain("t1");

        issue("t2_mul", 4'b0010, 32'd7, 32'd6, 32'hDEAD, 32'd42, 32'd0, 1'b0, 33);
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            nb++;
            @(negedge clk);
        end
        check("t2_busy_cycles", 64'(nb), 64'd32);
        drain("t2");

        issue("t3_div", 4'b0011, 32'd100, 32'd7, 32'h1234, 32'd14, 32'd2, 1'b0, 33);
        drain("t3");

`ifdef ALU_SEQ_DIVZERO_EN
        issue("t4_divz", 4'b0011, 32'd9, 32'd0, 32'h0, 32'hFFFFFFFF, 32'd9, 1'b1, 1);
`else
        issue("t4_divz", 4'b0011, 32'd9, 32'd0, 32'h0, 32'hFFFFFFFF, 32'd9, 1'b0, 33);
`endif
        drain("t4");

        issue("sel_f", 4'b1111, 32'd1, 32'd1, 32'hABCD, 32'hABCD, 32'd0, 1'b0, 1);
        issue("mul_big", 4'b0010, 32'h00010000, 32'h00010001, 32'h0, 32'h00010000, 32'd0, 1'b0, 33);
        drain("mul_big");
        issue("mul_ones", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'd0, 1'b0, 33);
        drain("mul_ones");
        issue("div_by1", 4'b0011, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 32'd0, 1'b0, 33);
        drain("div_by1");
        issue("div_small", 4'b0011, 32'd5, 32'd9, 32'h0, 32'd0, 32'd5, 1'b0, 33);
        drain("div_small");

        drive(4'b0010, 32'd3, 32'd4, 32'h0);
        repeat (3) @(negedge clk);
        drive(4'b0000, 32'd1, 32'd1, 32'h77);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_done", 64'(bus.done), 64'd0);
        check("t5_result", 64'(bus.result), 64'd0);
        repeat (40) @(negedge clk);
        issue("t5_add", 4'b0000, 32'd10, 32'd20, 32'd30, 32'd30, 32'd0, 1'b0, 1);
        drain("t5");

        issue("t6_add", 4'b0000, 32'd1, 32'd2, 32'd3, 32'd3, 32'd0, 1'b0, 1);
        issue("t6_sub", 4'b0001, 32'd9, 32'd4, 32'd5, 32'd5, 32'd0, 1'b0, 1);
        issue("t6_mul", 4'b0010, 32'd3, 32'd5, 32'h0, 32'd15, 32'd0, 1'b0, 33);
        drain("t6");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
